// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB shadow/active register bank.
package opb_regbank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam int PENDING_BIT = 0;
    localparam int COUNT_LSB   = 16;

    // be[3] enables value bits 31:24, be[0] enables value bits 7:0.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/opb_regbank_decode.sv
// Combinational address-window hit and word-index decode for the register bank.
module opb_regbank_decode #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter int          IDX_W        = 4
) (
    input  logic [C_OPB_AWIDTH-1:0] addr,
    input  logic                    select,
    output logic                    hit,
    output logic                    is_data,
    output logic                    is_ctrl,
    output logic [IDX_W-1:0]        idx
);

    localparam logic [C_OPB_AWIDTH-1:0] BASE  = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] HIGH  = C_OPB_AWIDTH'(C_HIGHADDR);
    localparam logic [C_OPB_AWIDTH-1:0] NUM_W = C_OPB_AWIDTH'(C_NUM_REGS);

    logic [C_OPB_AWIDTH-1:0] word;

    always_comb begin
        word    = (addr - BASE) >> 2;
        hit     = select && (addr >= BASE) && (addr <= HIGH);
        is_data = hit && (word < NUM_W);
        is_ctrl = hit && (word == NUM_W);
        idx     = word[IDX_W-1:0];
    end

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave with C_NUM_REGS shadow registers committed atomically to an active copy.
// Define OPB_REGBANK_SYNC_COMMIT_EN to defer commits until the next user_sync strobe.
module opb_register_bank
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter int          C_REG_WIDTH  = 32,
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst_n,
    input  logic [0:31]                       OPB_ABus,
    input  logic [0:3]                        OPB_BE,
    input  logic [0:31]                       OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:31]                       Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    input  logic                              user_sync,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic                              user_commit_pulse,
    output logic                              user_commit_pending
);

    localparam int              IDX_W = $clog2(C_NUM_REGS + 1);
    localparam int              RW    = C_REG_WIDTH;
    localparam logic [RW-1:0]   INIT  = C_INIT_VALUE[RW-1:0];

    state_t                  state_reg, state_next;
    logic                    hit, is_data, is_ctrl;
    logic [IDX_W-1:0]        idx;

    logic                    rnw_reg, is_data_reg, is_ctrl_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [31:0]             wdata_reg;
    logic [3:0]              be_reg;
    logic [C_OPB_DWIDTH-1:0] dbus_reg;

    logic                    pending_reg;
    logic [15:0]             count_reg;

    logic [C_NUM_REGS*RW-1:0] shadow_flat;
    logic [RW-1:0]           rd_shadow;
    logic [31:0]             rdata;
    logic [31:0]             full_mask;
    logic [RW-1:0]           wr_mask;
    logic                    ack, wr_fire, commit_req, commit_apply;
    logic                    unused_inputs;

    opb_regbank_decode #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_NUM_REGS   (C_NUM_REGS),
        .IDX_W        (IDX_W)
    ) u_decode (
        .addr    (OPB_ABus),
        .select  (OPB_select),
        .hit     (hit),
        .is_data (is_data),
        .is_ctrl (is_ctrl),
        .idx     (idx)
    );

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (hit) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ack        = (state_reg == ACK);
    assign wr_fire    = ack && !rnw_reg;
    // Only the low byte lane carries the commit bit.
    assign commit_req = wr_fire && is_ctrl_reg && be_reg[0] && wdata_reg[0];

`ifdef OPB_REGBANK_SYNC_COMMIT_EN
    assign commit_apply = pending_reg && user_sync;
`else
    assign commit_apply = pending_reg;
`endif

    always_comb begin
        rd_shadow = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) rd_shadow = shadow_flat[i*RW +: RW];
        end
        rdata = '0;
        if (is_data) begin
            rdata = 32'(rd_shadow);
        end else if (is_ctrl) begin
            rdata[COUNT_LSB +: 16] = count_reg;
            rdata[PENDING_BIT]     = pending_reg;
        end
    end

    // Transfer attributes are captured at the hit edge; the write lands when ACK ends.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rnw_reg     <= 1'b0;
            is_data_reg <= 1'b0;
            is_ctrl_reg <= 1'b0;
            idx_reg     <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            dbus_reg    <= '0;
        end else begin
            dbus_reg <= '0;
            if (state_reg == IDLE && hit) begin
                rnw_reg     <= OPB_RNW;
                is_data_reg <= is_data;
                is_ctrl_reg <= is_ctrl;
                idx_reg     <= idx;
                wdata_reg   <= OPB_DBus;
                be_reg      <= OPB_BE;
                if (OPB_RNW) dbus_reg <= rdata;
            end
        end
    end

    // A request arriving as a pending commit is consumed keeps pending set.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            pending_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            pending_reg <= (pending_reg && !commit_apply) || commit_req;
            if (commit_apply) count_reg <= count_reg + 16'd1;
        end
    end

    assign full_mask = be_to_mask(be_reg);
    assign wr_mask   = full_mask[RW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            logic [RW-1:0] shadow_reg;
            logic [RW-1:0] active_reg;
            logic          wr_sel;

            assign wr_sel = wr_fire && is_data_reg && (idx_reg == IDX_W'(gi));

            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    shadow_reg <= INIT;
                    active_reg <= INIT;
                end else begin
                    if (wr_sel) shadow_reg <= (shadow_reg & ~wr_mask) | (wdata_reg[RW-1:0] & wr_mask);
                    if (commit_apply) active_reg <= shadow_reg;
                end
            end

            assign shadow_flat[gi*RW +: RW]   = shadow_reg;
            assign user_data_out[gi*RW +: RW] = active_reg;
        end
    endgenerate

    assign Sl_DBus             = dbus_reg;
    assign Sl_xferAck          = ack;
    assign Sl_errAck           = 1'b0;
    assign Sl_retry            = 1'b0;
    assign Sl_toutSup          = 1'b0;
    assign user_commit_pulse   = commit_apply;
    assign user_commit_pending = pending_reg;
    assign unused_inputs       = ^{OPB_seqAddr, user_sync};

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank with a transaction-level shadow/active model.
module tb_opb_register_bank;

    localparam int          NR   = 8;
    localparam int          RW   = 32;
    localparam logic [31:0] INIT = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] abus = '0;
    logic [0:31] dbus = '0;
    logic [0:3]  be = '0;
    logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0, sync = 1'b0;

    logic [0:31]        sl_dbus;
    logic               ack, err, retry, tout, pulse, pend;
    logic [NR*RW-1:0]   udata;

    opb_register_bank #(
        .C_BASEADDR   (32'h0000_0000),
        .C_HIGHADDR   (32'h0000_00FF),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (NR),
        .C_REG_WIDTH  (RW),
        .C_INIT_VALUE (INIT)
    ) dut (
        .OPB_Clk             (clk),
        .OPB_Rst_n           (rst_n),
        .OPB_ABus            (abus),
        .OPB_BE              (be),
        .OPB_DBus            (dbus),
        .OPB_RNW             (rnw),
        .OPB_select          (sel),
        .OPB_seqAddr         (seq),
        .Sl_DBus             (sl_dbus),
        .Sl_xferAck          (ack),
        .Sl_errAck           (err),
        .Sl_retry            (retry),
        .Sl_toutSup          (tout),
        .user_sync           (sync),
        .user_data_out       (udata),
        .user_commit_pulse   (pulse),
        .user_commit_pending (pend)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [31:0] shadow_m [NR];
    logic [31:0] active_m [NR];
    bit          pending_m;
    int unsigned count_m;
    bit          exp_ack;
    logic [31:0] exp_dbus;
    bit          checking = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            shadow_m[i] = INIT;
            active_m[i] = INIT;
        end
        pending_m = 0;
        count_m   = 0;
        exp_ack   = 0;
        exp_dbus  = '0;
    endfunction

    function automatic logic [NR*RW-1:0] active_flat();
        logic [NR*RW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*RW +: RW] = active_m[i];
        return f;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx < NR)  return shadow_m[idx];
        if (idx == NR) return ((count_m % 65536) << 16) | 32'(pending_m);
        return 32'h0;
    endfunction

    // Returns 1 when the write is a commit request.
    function automatic bit model_write(input int idx, input logic [0:3] bm, input logic [31:0] d);
        logic [31:0] m;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (bm[b]) begin
                    m = 32'hFF00_0000 >> (8 * b);
                    shadow_m[idx] = (shadow_m[idx] & ~m) | (d & m);
                end
            end
            return 0;
        end
        if (idx == NR) return bm[3] && d[0];
        return 0;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < NR; i++) active_m[i] = shadow_m[i];
        count_m++;
        pending_m = 0;
    endfunction

    function automatic bit exp_pulse();
`ifdef OPB_REGBANK_SYNC_COMMIT_EN
        return pending_m && sync;
`else
        return pending_m;
`endif
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("xferAck", 256'(ack), 256'(exp_ack));
            chk("Sl_DBus", 256'(sl_dbus), 256'(exp_dbus));
            chk("commit_pulse", 256'(pulse), 256'(exp_pulse()));
            chk("commit_pending", 256'(pend), 256'(pending_m));
            chk("user_data_out", 256'(udata), 256'(active_flat()));
            chk("tied_zero", 256'({err, retry, tout}), 256'(0));
        end
    end

    // Called at posedge+1; leaves the bench at posedge+1 inside the ACK cycle.
    task automatic start_xfer(input bit r, input int idx, input logic [3:0] b, input logic [31:0] d);
        abus = 32'(idx * 4);
        rnw  = r;
        be   = b;
        dbus = d;
        sel  = 1'b1;
        @(posedge clk); #1;
        sel  = 1'b0;
        rnw  = 1'b0;
        be   = '0;
        dbus = '0;
        abus = '0;
        exp_ack  = 1;
        exp_dbus = r ? model_read(idx) : 32'h0;
    endtask

    task automatic xfer(input bit r, input int idx, input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd);
        bit c;
        start_xfer(r, idx, b, d);
        rd = sl_dbus;
        @(posedge clk); #1;
        exp_ack  = 0;
        exp_dbus = '0;
        if (!r) begin
            c = model_write(idx, b, d);
            if (c) begin
                pending_m = 1;
`ifndef OPB_REGBANK_SYNC_COMMIT_EN
                @(posedge clk); #1;
                model_commit();
`endif
            end
        end
    endtask

    task automatic sync_pulse();
        sync = 1'b1;
        @(posedge clk); #1;
`ifdef OPB_REGBANK_SYNC_COMMIT_EN
        if (pending_m) model_commit();
`endif
        sync = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]      rd;
        logic [NR*RW-1:0] ud;
        logic [NR*RW-1:0] rep5;
        rep5 = {NR{INIT}};
        model_reset();
        checking = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_user_data", 256'(udata), 256'(rep5));
        chk("reset_ack", 256'(ack), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(1, 0, 4'hF, 32'h0, rd);
        chk("read_idx0_init", 256'(rd), 256'(32'h0000_0005));

        xfer(0, 2, 4'b0011, 32'hDEAD_BEEF, rd);
        xfer(1, 2, 4'hF, 32'h0, rd);
        chk("read_idx2_partial", 256'(rd), 256'(32'h0000_BEEF));
        ud = udata;
        chk("reg2_out_before_commit", 256'(ud[2*RW +: RW]), 256'(32'h0000_0005));

        xfer(0, NR, 4'hF, 32'h1, rd);
`ifdef OPB_REGBANK_SYNC_COMMIT_EN
        repeat (10) begin
            @(posedge clk); #1;
        end
        sync_pulse();
        sync_pulse();
`else
        sync_pulse();
`endif
        ud = udata;
        chk("reg2_out_after_commit", 256'(ud[2*RW +: RW]), 256'(32'h0000_BEEF));
        xfer(1, NR, 4'hF, 32'h0, rd);
        chk("ctrl_after_commit", 256'(rd), 256'(32'h0001_0000));

        xfer(0, 0, 4'b1000, 32'hA1B2_C3D4, rd);
        xfer(1, 0, 4'hF, 32'h0, rd);
        chk("read_idx0_msbyte", 256'(rd), 256'(32'hA100_0005));
        xfer(0, 5, 4'b0101, 32'h1122_3344, rd);
        xfer(1, 5, 4'hF, 32'h0, rd);
        chk("read_idx5_bytes", 256'(rd), 256'(32'h0022_0044));
        xfer(0, 7, 4'hF, 32'hCAFE_F00D, rd);

        // Control writes that must not commit.
        xfer(0, NR, 4'b1110, 32'h1, rd);
        xfer(0, NR, 4'hF, 32'h2, rd);
        xfer(1, NR, 4'hF, 32'h0, rd);
        chk("ctrl_no_commit", 256'(rd), 256'(32'h0001_0000));

        xfer(0, NR + 3, 4'hF, 32'hFFFF_FFFF, rd);
        xfer(1, NR + 3, 4'hF, 32'h0, rd);
        chk("read_unused_idx", 256'(rd), 256'(32'h0));
        xfer(1, 63, 4'hF, 32'h0, rd);
        chk("read_last_word", 256'(rd), 256'(32'h0));

        // Address just past the window: never acknowledged.
        abus = 32'h0000_0100;
        rnw  = 1'b1;
        sel  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        sel  = 1'b0;
        rnw  = 1'b0;
        abus = '0;
        @(posedge clk); #1;

        xfer(0, NR, 4'b0001, 32'h1, rd);
`ifdef OPB_REGBANK_SYNC_COMMIT_EN
        sync_pulse();
`endif
        xfer(1, NR, 4'hF, 32'h0, rd);
        chk("ctrl_second_commit", 256'(rd), 256'(32'h0002_0000));
        ud = udata;
        chk("reg7_out", 256'(ud[7*RW +: RW]), 256'(32'hCAFE_F00D));

        // Reset asserted in the middle of a write's ACK cycle.
        start_xfer(0, 1, 4'hF, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ack_drop_on_reset", 256'(ack), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1, 4'hF, 32'h0, rd);
        chk("idx1_after_reset", 256'(rd), 256'(32'h0000_0005));
        xfer(1, NR, 4'hF, 32'h0, rd);
        chk("ctrl_after_reset", 256'(rd), 256'(32'h0));
        ud = udata;
        chk("user_data_after_reset", 256'(ud), 256'(rep5));

        @(posedge clk); #1;
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
